// File: rtl/imem_loader.sv
// Instruction memory loader: takes a byte stream (2-byte big-endian word count, then
// 4 bytes per word, MSB first), writes the assembled words from address 0 and holds
// the CPU in reset until a load completes successfully.
// Optional feature: define IMEM_LOADER_CSUM_EN to require a trailing XOR checksum byte.
module imem_loader #(
  parameter int unsigned MAX_WORDS = 256,
  parameter int unsigned ADDR_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              we,
  output logic [ADDR_W-1:0] wa,
  output logic [31:0]       wd,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              cpu_rst
);

  typedef enum logic [2:0] {
    StIdle,
    StHdrHi,
    StHdrLo,
    StData,
    StWrite,
    StDone,
    StErr
`ifdef IMEM_LOADER_CSUM_EN
    , StCsum
`endif
  } state_e;

  state_e            state_q;
  logic [15:0]       n_q;
  logic [15:0]       idx_q;
  logic [1:0]        cnt_q;
  logic [23:0]       asm_q;
  logic              in_ready_q;
  logic              we_q;
  logic [ADDR_W-1:0] wa_q;
  logic [31:0]       wd_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic              cpu_rst_q;
`ifdef IMEM_LOADER_CSUM_EN
  logic [7:0]        csum_q;
`endif

  logic        xfer;
  logic [15:0] idx_inc;
  logic [15:0] n_full;

  // Handshake qualifier and helper values used by the FSM.
  always_comb begin
    xfer    = in_valid && in_ready_q;
    idx_inc = idx_q + 16'd1;
    n_full  = {n_q[15:8], in_data};
  end

  // Loader FSM; every output is a register updated together with the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      n_q        <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      asm_q      <= '0;
      in_ready_q <= 1'b0;
      we_q       <= 1'b0;
      wa_q       <= '0;
      wd_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      cpu_rst_q  <= 1'b1;
`ifdef IMEM_LOADER_CSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      we_q <= 1'b0;
`ifdef IMEM_LOADER_CSUM_EN
      if (xfer) csum_q <= csum_q ^ in_data;
`endif
      case (state_q)
        StIdle, StDone, StErr: begin
          if (start) begin
            state_q    <= StHdrHi;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b1;
            cpu_rst_q  <= 1'b1;
            idx_q      <= '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b1;
`ifdef IMEM_LOADER_CSUM_EN
            csum_q     <= '0;
`endif
          end
        end
        StHdrHi: begin
          if (xfer) begin
            n_q[15:8] <= in_data;
            state_q   <= StHdrLo;
          end
        end
        StHdrLo: begin
          if (xfer) begin
            n_q[7:0] <= in_data;
            if (n_full == 16'd0) begin
`ifdef IMEM_LOADER_CSUM_EN
              state_q    <= StCsum;
`else
              state_q    <= StDone;
              in_ready_q <= 1'b0;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
              cpu_rst_q  <= 1'b0;
`endif
            end else if (32'(n_full) > MAX_WORDS) begin
              state_q    <= StErr;
              in_ready_q <= 1'b0;
              busy_q     <= 1'b0;
              err_q      <= 1'b1;
            end else begin
              state_q <= StData;
            end
          end
        end
        StData: begin
          if (xfer) begin
            asm_q <= {asm_q[15:0], in_data};
            if (cnt_q == 2'd3) begin
              // Fourth byte: present the write during the following (WRITE) cycle.
              cnt_q      <= '0;
              we_q       <= 1'b1;
              wa_q       <= ADDR_W'(idx_q);
              wd_q       <= {asm_q, in_data};
              in_ready_q <= 1'b0;
              state_q    <= StWrite;
            end else begin
              cnt_q <= cnt_q + 2'd1;
            end
          end
        end
        StWrite: begin
          idx_q <= idx_inc;
          if (idx_inc == n_q) begin
`ifdef IMEM_LOADER_CSUM_EN
            state_q    <= StCsum;
            in_ready_q <= 1'b1;
`else
            state_q    <= StDone;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            cpu_rst_q  <= 1'b0;
`endif
          end else begin
            state_q    <= StData;
            in_ready_q <= 1'b1;
          end
        end
`ifdef IMEM_LOADER_CSUM_EN
        StCsum: begin
          if (xfer) begin
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            if ((csum_q ^ in_data) == 8'h00) begin
              state_q   <= StDone;
              done_q    <= 1'b1;
              cpu_rst_q <= 1'b0;
            end else begin
              state_q <= StErr;
              err_q   <= 1'b1;
            end
          end
        end
`endif
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready = in_ready_q;
  assign we       = we_q;
  assign wa       = wa_q;
  assign wd       = wd_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign cpu_rst  = cpu_rst_q;

endmodule
